// File: rtl/rram_ctrl_pkg.sv
// rram_ctrl_pkg: shared states, layer bit ranges and default timing for the RRAM crossbar controllers
package rram_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE, FWD1, SET1, FWD2, SET2, FWD3, SET3, LABEL, BACK, DONE
    } state_t;

    localparam int L1_MSB = 11;
    localparam int L2_MSB = 7;
    localparam int L3_MSB = 3;
    localparam logic [3:0] L3_MASK = 4'b1110;

    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_SET_CYC    = 1;
    localparam int DEF_BACK_CYC   = 8;
    localparam int TMR_W          = 8;

endpackage

// File: rtl/rram_phase_timer.sv
// rram_phase_timer: loadable down-counter that parks at zero and flags it
module rram_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // load on phase entry, otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rram_train_sequencer.sv
// rram_train_sequencer: steps the 3-layer RRAM crossbar through forward and optional backward passes
module rram_train_sequencer
    import rram_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int SET_CYC    = DEF_SET_CYC,
    parameter int BACK_CYC   = DEF_BACK_CYC,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic [2:0]       in_label,
    input  logic             train_en,
    input  logic             abort,
    output logic [11:0]      Dwl,
    output logic [11:0]      Dsl,
    output logic [11:0]      Dbl,
    output logic             Dset,
    output logic             Dback,
    output logic [2:0]       Dlabel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt
);

    state_t           state, nxt;
    logic [3:0]       data_q;
    logic [2:0]       label_q;
    logic             train_q;
    logic             tzero;
    logic             load;
    logic [TMR_W-1:0] ld_val;

    assign in_ready = rst_n && state == IDLE && !abort;
    assign busy     = state != IDLE;
    assign load     = nxt != state;

    // next phase: advance when the phase timer has expired, abort overrides
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = (in_valid && in_ready) ? FWD1 : IDLE;
            FWD1:  nxt = tzero ? SET1 : FWD1;
            SET1:  nxt = tzero ? FWD2 : SET1;
            FWD2:  nxt = tzero ? SET2 : FWD2;
            SET2:  nxt = tzero ? FWD3 : SET2;
            FWD3:  nxt = tzero ? SET3 : FWD3;
            SET3:  nxt = tzero ? (train_q ? LABEL : DONE) : SET3;
            LABEL: nxt = BACK;
            BACK:  nxt = tzero ? DONE : BACK;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort && state != IDLE)
            nxt = IDLE;
    end

    // timer reload value is the length of the phase being entered, minus one
    always_comb begin
        ld_val = '0;
        case (nxt)
            FWD1, FWD2, FWD3: ld_val = TMR_W'(SETTLE_CYC - 1);
            SET1, SET2, SET3: ld_val = TMR_W'(SET_CYC - 1);
            BACK:             ld_val = TMR_W'(BACK_CYC - 1);
            default:          ld_val = '0;
        endcase
    end

    rram_phase_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (ld_val),
        .zero     (tzero)
    );

    // state register, sample latch and completed-transaction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            data_q     <= '0;
            label_q    <= '0;
            train_q    <= 1'b0;
            sample_cnt <= '0;
        end else begin
            state <= nxt;
            if (in_valid && in_ready) begin
                data_q  <= in_data;
                label_q <= in_label;
                train_q <= train_en;
            end
            if (state == DONE && !abort)
                sample_cnt <= sample_cnt + 1'b1;
        end
    end

    // line-drive decode from the current phase
    always_comb begin
        Dwl    = '0;
        Dsl    = '0;
        Dbl    = '0;
        Dback  = 1'b0;
        Dlabel = '0;
        done   = 1'b0;
        case (state)
            FWD1, SET1: begin
                Dwl[L1_MSB -: 4] = 4'hF;
                Dsl[L1_MSB -: 4] = data_q;
                Dbl[L1_MSB -: 4] = 4'hF;
            end
            FWD2, SET2: begin
                Dwl[L2_MSB -: 4] = 4'hF;
                Dsl[L2_MSB -: 4] = 4'hF;
                Dbl[L2_MSB -: 4] = 4'hF;
            end
            FWD3, SET3: begin
                Dwl[L3_MSB -: 4] = L3_MASK;
                Dsl[L3_MSB -: 4] = L3_MASK;
                Dbl[L3_MSB -: 4] = L3_MASK;
            end
            LABEL: Dlabel = label_q;
            BACK: begin
                Dwl    = {4'hF, 4'hF, L3_MASK};
                Dbl    = {4'hF, 4'hF, L3_MASK};
                Dback  = 1'b1;
                Dlabel = label_q;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
        Dset = state inside {SET1, SET2, SET3};
    end

endmodule

// File: tb/tb_rram_train_sequencer.sv
// tb_rram_train_sequencer: cycle-schedule model plus directed transactions for the training sequencer
module tb_rram_train_sequencer;

    localparam int S = 4, T = 1, B = 8, P = S + T;

    logic        clk, rst_n, in_valid, train_en, abort;
    logic [3:0]  in_data;
    logic [2:0]  in_label;
    logic        in_ready, Dset, Dback, busy, done;
    logic [11:0] Dwl, Dsl, Dbl;
    logic [2:0]  Dlabel;
    logic [15:0] sample_cnt;
    logic        q_ready, q_set, q_back, q_busy, q_done;
    logic [11:0] q_wl, q_sl, q_bl;
    logic [2:0]  q_label;
    logic [1:0]  q_cnt;

    int checks = 0, errors = 0;

    rram_train_sequencer #(.SETTLE_CYC(S), .SET_CYC(T), .BACK_CYC(B), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_label(in_label), .train_en(train_en), .abort(abort), .Dwl(Dwl), .Dsl(Dsl), .Dbl(Dbl),
        .Dset(Dset), .Dback(Dback), .Dlabel(Dlabel), .busy(busy), .done(done), .sample_cnt(sample_cnt)
    );

    rram_train_sequencer #(.SETTLE_CYC(S), .SET_CYC(T), .BACK_CYC(B), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(q_ready), .in_data(in_data),
        .in_label(in_label), .train_en(train_en), .abort(abort), .Dwl(q_wl), .Dsl(q_sl), .Dbl(q_bl),
        .Dset(q_set), .Dback(q_back), .Dlabel(q_label), .busy(q_busy), .done(q_done), .sample_cnt(q_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] wl, sl, bl;
        logic        set, back;
        logic [2:0]  label;
        logic        busy, done;
    } exp_t;

    // expected outputs k cycles after the transfer edge (k=0 means idle)
    function automatic exp_t expect_at(int k, logic [3:0] d, logic [2:0] l, bit tr);
        exp_t e;
        int ly;
        logic [3:0] lines;
        e = '0;
        if (k == 0) return e;
        e.busy = 1;
        if (k <= 3 * P) begin
            ly    = (k - 1) / P;
            lines = (ly == 2) ? 4'b1110 : 4'hF;
            e.wl  = 12'(lines) << (8 - 4 * ly);
            e.bl  = e.wl;
            e.sl  = (ly == 0) ? {d, 8'h00} : e.wl;
            e.set = ((k - 1) % P) >= S;
        end else if (tr && k == 3 * P + 1) begin
            e.label = l;
        end else if (tr && k <= 3 * P + 1 + B) begin
            e.label = l;
            e.back  = 1;
            e.wl    = 12'hFFE;
            e.bl    = 12'hFFE;
        end else begin
            e.done = 1;
        end
        return e;
    endfunction

    int          mk;
    logic [3:0]  md;
    logic [2:0]  ml;
    bit          mt;
    logic [15:0] mcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mk = 0;
            mcnt = 0;
        end else if (mk > 0) begin
            if (abort) mk = 0;
            else if (mk == 3 * P + 1 + (mt ? 1 + B : 0)) begin
                mk = 0;
                mcnt = mcnt + 1;
            end else mk = mk + 1;
        end else if (in_valid && !abort) begin
            mk = 1;
            md = in_data;
            ml = in_label;
            mt = train_en;
        end
    end

    always @(posedge clk) begin
        exp_t e, a;
        logic er;
        #2;
        e  = expect_at(mk, md, ml, mt);
        a  = {Dwl, Dsl, Dbl, Dset, Dback, Dlabel, busy, done};
        er = rst_n && mk == 0 && !abort;
        checks++;
        if (a !== e || in_ready !== er || sample_cnt !== mcnt || q_cnt !== mcnt[1:0]) begin
            errors++;
            $display("FAIL cycle k=%0d t=%0t got outs=%h ready=%b cnt=%0d cnt2=%0d want outs=%h ready=%b cnt=%0d",
                     mk, $time, a, in_ready, sample_cnt, q_cnt, e, er, mcnt);
        end
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    logic [11:0] h_wl[64], h_sl[64];
    logic [2:0]  h_lab[64];
    logic        h_busy[64], h_ready[64];
    logic [63:0] m_set, m_done, m_back, m_lab;

    task automatic run_tx(input logic [3:0] d, input logic [2:0] l, input bit tr,
                          input int abort_at, input bit hold, input int n);
        int w = 0;
        @(negedge clk);
        in_valid = 1; in_data = d; in_label = l; train_en = tr;
        #1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 50) chk("accept_timeout", 64'(w), 64'd0);
        @(posedge clk);
        m_set = 0; m_done = 0; m_back = 0; m_lab = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            h_wl[k] = Dwl; h_sl[k] = Dsl; h_lab[k] = Dlabel;
            h_busy[k] = busy; h_ready[k] = in_ready;
            m_set[k] = Dset; m_done[k] = done; m_back[k] = Dback; m_lab[k] = Dlabel != 0;
            if (!hold) in_valid = 0;
            abort = (k == abort_at);
        end
        in_valid = 0;
        abort = 0;
    endtask

    int e2[5] = '{1, 2, 3, 0, 1};

    initial begin
        rst_n = 0; in_valid = 0; in_data = 0; in_label = 0; train_en = 0; abort = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("reset_ready", 64'(in_ready), 64'd1);
        chk("reset_cnt", 64'(sample_cnt), 64'd0);

        run_tx(4'b1010, 3'b001, 0, 0, 0, 18);
        chk("inf_sl_c1", 64'(h_sl[1][11:8]), 64'hA);
        chk("inf_sl_c5", 64'(h_sl[5][11:8]), 64'hA);
        chk("inf_wl_c6", 64'(h_wl[6]), 64'h0F0);
        chk("inf_wl_c11", 64'(h_wl[11]), 64'h00E);
        chk("inf_set", m_set, 64'h8420);
        chk("inf_done", m_done, 64'h10000);
        chk("inf_back", m_back, 64'h0);
        chk("inf_cnt", 64'(sample_cnt), 64'd1);

        run_tx(4'b1100, 3'b010, 1, 0, 0, 27);
        chk("trn_label_val", 64'(h_lab[16]), 64'h2);
        chk("trn_label", m_lab, 64'h01FF0000);
        chk("trn_back", m_back, 64'h01FE0000);
        chk("trn_wl_c17", 64'(h_wl[17]), 64'hFFE);
        chk("trn_wl_c24", 64'(h_wl[24]), 64'hFFE);
        chk("trn_done", m_done, 64'h02000000);
        chk("trn_cnt", 64'(sample_cnt), 64'd2);

        run_tx(4'b0011, 3'b100, 1, 20, 0, 24);
        chk("abt_busy_c20", 64'(h_busy[20]), 64'd1);
        chk("abt_busy_c21", 64'(h_busy[21]), 64'd0);
        chk("abt_wl_c21", 64'(h_wl[21]), 64'h0);
        chk("abt_ready_c21", 64'(h_ready[21]), 64'd0);
        chk("abt_ready_c22", 64'(h_ready[22]), 64'd1);
        chk("abt_done", m_done, 64'h0);
        chk("abt_cnt", 64'(sample_cnt), 64'd2);
        run_tx(4'b0101, 3'b001, 0, 0, 0, 18);
        chk("abt_next_done", m_done, 64'h10000);
        chk("abt_next_cnt", 64'(sample_cnt), 64'd3);

        run_tx(4'b1111, 3'b001, 0, 0, 1, 34);
        chk("b2b_busy_c16", 64'(h_busy[16]), 64'd1);
        chk("b2b_busy_c17", 64'(h_busy[17]), 64'd0);
        chk("b2b_busy_c18", 64'(h_busy[18]), 64'd1);
        chk("b2b_done", m_done, (64'd1 << 16) | (64'd1 << 33));
        chk("b2b_cnt", 64'(sample_cnt), 64'd5);

        run_tx(4'b0110, 3'b001, 0, 0, 0, 7);
        chk("rst_pre_wl", 64'(h_wl[7]), 64'h0F0);
        #2;
        rst_n = 0;
        #1;
        chk("rst_outs", 64'({Dwl, Dsl, Dbl, Dset, Dback, Dlabel, busy, done, in_ready}), 64'h0);
        chk("rst_cnt", 64'(sample_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_rel_ready", 64'(in_ready), 64'd1);
        chk("rst_rel_cnt", 64'(sample_cnt), 64'd0);

        for (int i = 0; i < 5; i++) begin
            run_tx(4'(i), 3'b001, 0, 0, 0, 18);
            chk($sformatf("cnt2_%0d", i), 64'(q_cnt), 64'(e2[i]));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/rram_train_sequencer.md
Name: rram_train_sequencer

Overview:
- Digital sequencer that drives the control pins of the 3-layer RRAM crossbar training unit: word-line, source-line and bit-line selects, sigmoid-conversion strobe (Dset), back-propagation enable (Dback) and the one-hot label.
- Accepts one 4-bit input sample plus 3-bit label per transaction over a valid/ready handshake.
- Steps the array through a layer-by-layer forward pass and an optional backward (weight-update) pass, then reports completion.
- Sits between the host/sample buffer and the analog crossbar unit.

Parameters:
- SETTLE_CYC, 4, cycles a layer's lines are held before its Dset strobe (1..255)
- SET_CYC, 1, width of each Dset strobe in cycles (1..15)
- BACK_CYC, 8, cycles Dback is held high during the update phase (1..255)
- CNT_W, 16, width of the completed-sample counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample/label presented
- in_ready  out  1  sequencer can accept a sample
- in_data  in  4  input feature bits for layer-1 source lines
- in_label  in  3  one-hot target label
- train_en  in  1  sampled with the sample; 1 = run the backward pass
- abort  in  1  synchronous abort to IDLE
- Dwl  out  12  word-line enables, [11:8] L1, [7:4] L2, [3:0] L3
- Dsl  out  12  source-line drive/enable, same layer split
- Dbl  out  12  bit-line enables, same layer split
- Dset  out  1  sigmoid-conversion sample strobe
- Dback  out  1  backward-pass enable
- Dlabel  out  3  label to the error calculators
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a transaction
- sample_cnt  out  CNT_W  completed transactions, wraps at 2^CNT_W

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All Dwl/Dsl/Dbl/Dset/Dback/Dlabel/busy/done = 0; sample_cnt = 0; in_ready = 0 while reset is asserted.
  - Outputs go low immediately, not at the next edge.
- in_ready = 1 only in IDLE. A transfer occurs on a clock edge with in_valid & in_ready.
- On transfer, latch in_data, in_label and train_en, then enter FWD1 on the next cycle.
- States: IDLE, FWD1, SET1, FWD2, SET2, FWD3, SET3, LABEL, BACK, DONE.
- FWDn (SETTLE_CYC cycles): drive the layer-n lines.
  - n=1: Dwl[11:8]=4'hF, Dsl[11:8]=latched in_data, Dbl[11:8]=4'hF.
  - n=2: Dwl/Dsl/Dbl[7:4]=4'hF.
  - n=3: Dwl/Dsl/Dbl[3:0]=4'b1110 (bit 0 unused, held 0).
  - All other layer bits are 0.
- SETn (SET_CYC cycles): hold the layer-n lines unchanged and set Dset=1. Dset is 0 in every other state.
- After SET3:
  - If latched train_en=1, go to LABEL.
  - Otherwise go to DONE.
- LABEL (1 cycle): all lines 0; Dlabel = latched label. Dlabel holds through BACK and clears in DONE.
- BACK (BACK_CYC cycles):
  - Dback=1.
  - All Dwl/Dbl = 12'hFFE (all layers enabled for the update).
  - Dsl = 0.
- DONE (1 cycle): all lines 0, done=1, sample_cnt increments, then IDLE.
- Latency:
  - Inference (train_en=0): 3*(SETTLE_CYC+SET_CYC)+1 cycles from transfer edge to done.
  - Training (train_en=1): add 1+BACK_CYC.
  - Defaults: 16 and 25 cycles.
- One shared phase counter is loaded on each state entry and counts down. A state transitions when the count reaches 0.
- abort=1 in any non-IDLE state:
  - Next cycle goes to IDLE with all lines 0.
  - No done pulse; sample_cnt is not incremented.
  - abort in IDLE is ignored but blocks acceptance: in_ready=0 while abort=1.
- in_label not one-hot: passed through unchanged; no checking.
- in_valid outside IDLE: ignored; no buffering.
- sample_cnt wrap: 2^CNT_W-1 goes to 0 with no flag.

Decomposition:
- Shared package rram_ctrl_pkg holds:
  - State enum.
  - Layer bit-range constants (L1_MSB=11, L2_MSB=7, L3_MSB=3).
  - Constant L3_MASK=4'b1110.
  - Default timing parameters.
- One sub-module, rram_phase_timer: a loadable down-counter with a zero flag, reusable by other crossbar controllers.
- Line-drive decode stays combinational inside the top module.

Test Plan:
- Reset mid-FWD2: drop rst_n → all outputs 0 within the same cycle; after release in_ready=1 and sample_cnt=0.
- Inference: in_data=4'b1010, train_en=0, defaults:
  - Dsl[11:8]=1010 for cycles 1-5 after transfer.
  - Dset high at cycles 5, 10, 15.
  - done at cycle 16; Dback never high; sample_cnt=1.
- Training: in_label=3'b010, train_en=1:
  - Dlabel=010 from cycle 16 through 24.
  - Dback high cycles 17-24 with Dwl=Dbl=12'hFFE.
  - done at cycle 25.
- Abort in BACK (cycle 20) → IDLE at cycle 21, all lines 0, no done, sample_cnt unchanged, next sample accepted.
- Back-to-back: in_valid held high over two samples → second transfer only on the cycle after done; in_valid during busy is ignored.
- CNT_W=2: run 5 inference transactions → sample_cnt sequence 1, 2, 3, 0, 1.
